// File: rtl/jump_rs_ctrl_pkg.sv
// Shared definitions for the jump/branch reservation station: FSM state
// encoding, the "operand valid" tag value and the compare-unit codes.
package jump_rs_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WAIT    = 3'd1,
    ST_EXEC    = 3'd2,
    ST_RESOLVE = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  // A producer tag of zero means the operand value is already present.
  localparam int TAG_NONE = 0;

  // Compare codes understood by the compare unit (RISC-V funct3 layout).
  localparam logic [2:0] CMP_EQ  = 3'b000;
  localparam logic [2:0] CMP_NE  = 3'b001;
  localparam logic [2:0] CMP_LT  = 3'b100;
  localparam logic [2:0] CMP_GE  = 3'b101;
  localparam logic [2:0] CMP_LTU = 3'b110;
  localparam logic [2:0] CMP_GEU = 3'b111;

  // Reference behaviour of the compare unit for a given code.
  function automatic logic cmp_taken(input logic [2:0] cmp,
                                     input logic [31:0] a,
                                     input logic [31:0] b);
    logic r;
    case (cmp)
      CMP_EQ:  r = (a == b);
      CMP_NE:  r = (a != b);
      CMP_LT:  r = ($signed(a) < $signed(b));
      CMP_GE:  r = ($signed(a) >= $signed(b));
      CMP_LTU: r = (a < b);
      CMP_GEU: r = (a >= b);
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/jump_rs_ctrl_operand.sv
// One operand slot of the reservation station: holds a producer tag and a
// value, snoops the CDB while waiting and bypasses a broadcast that lands
// in the same cycle the op is issued.
module jump_rs_operand_slot
  import jump_rs_ctrl_pkg::*;
#(
  parameter int TAG_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             load,       // op accepted this cycle
  input  logic             snoop,      // slot is waiting on the CDB
  input  logic [TAG_W-1:0] issue_q,
  input  logic [31:0]      issue_v,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic [31:0]      cdb_data,
  output logic [31:0]      value,
  output logic             ready_nxt   // tag will be zero after this edge
);

  logic [TAG_W-1:0] tag;
  logic             issue_hit;
  logic             snoop_hit;

  assign issue_hit = cdb_valid && (issue_q != TAG_W'(TAG_NONE)) && (cdb_tag == issue_q);
  assign snoop_hit = cdb_valid && (tag != TAG_W'(TAG_NONE)) && (cdb_tag == tag);
  assign ready_nxt = load ? ((issue_q == TAG_W'(TAG_NONE)) || issue_hit)
                          : ((tag == TAG_W'(TAG_NONE)) || snoop_hit);

  // Tag/value register: load on issue (with bypass), capture on CDB match.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag   <= '0;
      value <= '0;
    end else if (flush) begin
      tag   <= '0;
    end else if (load) begin
      if (issue_hit) begin
        tag   <= '0;
        value <= cdb_data;
      end else begin
        tag   <= issue_q;
        value <= issue_v;
      end
    end else if (snoop && snoop_hit) begin
      tag   <= '0;
      value <= cdb_data;
    end
  end

endmodule

// File: rtl/jump_rs_ctrl.sv
// Single-entry reservation station and sequencer for the jump/branch FU.
// Optional statistics counters are built when JUMP_RS_STATS_EN is defined.
module jump_rs_ctrl
  import jump_rs_ctrl_pkg::*;
#(
  parameter int TAG_W  = 3,
  parameter int FU_LAT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             issue_valid,
  output logic             issue_ready,
  input  logic             issue_jalr,
  input  logic             issue_branch,
  input  logic [2:0]       issue_cmp_ctrl,
  input  logic [31:0]      issue_pc,
  input  logic [31:0]      issue_imm,
  input  logic [TAG_W-1:0] issue_q1,
  input  logic [TAG_W-1:0] issue_q2,
  input  logic [31:0]      issue_v1,
  input  logic [31:0]      issue_v2,
  input  logic [TAG_W-1:0] issue_dst_tag,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic [31:0]      cdb_data,
  output logic             fu_en,
  output logic             fu_jalr,
  output logic [2:0]       fu_cmp_ctrl,
  output logic [31:0]      fu_rs1,
  output logic [31:0]      fu_rs2,
  output logic [31:0]      fu_imm,
  output logic [31:0]      fu_pc,
  input  logic [31:0]      fu_pc_jump,
  input  logic [31:0]      fu_pc_wb,
  input  logic             fu_cmp_res,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic             wb_valid,
  input  logic             wb_ready,
  output logic [TAG_W-1:0] wb_tag,
  output logic [31:0]      wb_data
`ifdef JUMP_RS_STATS_EN
  ,
  output logic [31:0]      stat_resolved,
  output logic [31:0]      stat_taken
`endif
);

  // Counter spans 0..FU_LAT: cycle 0 is the fu_en cycle, cycle FU_LAT samples results.
  localparam int CNT_W = (FU_LAT < 1) ? 1 : $clog2(FU_LAT + 1);

  state_t     state;
  logic [CNT_W-1:0] cnt;
  logic       is_branch;
  logic       redirect_q;
  logic       load;
  logic       rdy1_nxt, rdy2_nxt;

  assign load = (state == ST_IDLE) && issue_valid && !flush;

  jump_rs_operand_slot #(.TAG_W(TAG_W)) u_slot1 (
    .clk(clk), .rst(rst), .flush(flush), .load(load), .snoop(state == ST_WAIT),
    .issue_q(issue_q1), .issue_v(issue_v1),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .value(fu_rs1), .ready_nxt(rdy1_nxt)
  );

  jump_rs_operand_slot #(.TAG_W(TAG_W)) u_slot2 (
    .clk(clk), .rst(rst), .flush(flush), .load(load), .snoop(state == ST_WAIT),
    .issue_q(issue_q2), .issue_v(issue_v2),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .value(fu_rs2), .ready_nxt(rdy2_nxt)
  );

  // The redirect pulse is registered but a flush in the RESOLVE cycle must
  // still kill it, so the flush gate is applied on the output.
  assign redirect_valid = redirect_q && !flush;

  // Sequencer FSM with registered handshake/FU outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      is_branch   <= 1'b0;
      issue_ready <= 1'b1;
      fu_en       <= 1'b0;
      fu_jalr     <= 1'b0;
      fu_cmp_ctrl <= '0;
      fu_imm      <= '0;
      fu_pc       <= '0;
      redirect_q  <= 1'b0;
      redirect_pc <= '0;
      wb_valid    <= 1'b0;
      wb_tag      <= '0;
      wb_data     <= '0;
    end else begin
      fu_en      <= 1'b0;
      redirect_q <= 1'b0;
      if (flush) begin
        state       <= ST_IDLE;
        cnt         <= '0;
        wb_valid    <= 1'b0;
        issue_ready <= 1'b1;
      end else begin
        case (state)
          ST_IDLE: begin
            if (issue_valid) begin
              fu_jalr     <= issue_jalr;
              fu_cmp_ctrl <= issue_cmp_ctrl;
              fu_imm      <= issue_imm;
              fu_pc       <= issue_pc;
              is_branch   <= issue_branch;
              wb_tag      <= issue_dst_tag;
              issue_ready <= 1'b0;
              if (rdy1_nxt && rdy2_nxt) begin
                state <= ST_EXEC;
                fu_en <= 1'b1;
              end else begin
                state <= ST_WAIT;
              end
            end
          end
          ST_WAIT: begin
            if (rdy1_nxt && rdy2_nxt) begin
              state <= ST_EXEC;
              fu_en <= 1'b1;
            end
          end
          ST_EXEC: begin
            if (cnt == CNT_W'(FU_LAT)) begin
              cnt         <= '0;
              state       <= ST_RESOLVE;
              redirect_q  <= !is_branch || fu_cmp_res;
              redirect_pc <= fu_pc_jump;
              wb_data     <= fu_pc_wb;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          ST_RESOLVE: begin
            if (is_branch) begin
              state       <= ST_IDLE;
              issue_ready <= 1'b1;
            end else begin
              state    <= ST_DONE;
              wb_valid <= 1'b1;
            end
          end
          ST_DONE: begin
            if (wb_ready) begin
              wb_valid    <= 1'b0;
              state       <= ST_IDLE;
              issue_ready <= 1'b1;
            end
          end
          default: begin
            state       <= ST_IDLE;
            issue_ready <= 1'b1;
          end
        endcase
      end
    end
  end

`ifdef JUMP_RS_STATS_EN
  // Resolution and taken-redirect counters, free-running with wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_resolved <= '0;
      stat_taken    <= '0;
    end else begin
      if (state == ST_RESOLVE && !flush) stat_resolved <= stat_resolved + 32'd1;
      if (redirect_valid) stat_taken <= stat_taken + 32'd1;
    end
  end
`endif

endmodule
